// File: rtl/rs485_frame_echo_if.sv
// Bus between the RS485 frame-echo block and its UART/transceiver side.
interface rs485_frame_echo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) ();
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              de;
  logic [ADDR_W:0]   frame_len;
  logic              frame_done;
  logic              err_ovf;
  logic              err_tmo;
  logic              rx_drop;

  // UART side: supplies received bytes and TX busy, consumes TX strobes and status.
  modport master (
    output rx_data, rx_valid, tx_busy,
    input  tx_data, tx_start, de, frame_len, frame_done, err_ovf, err_tmo, rx_drop
  );

  modport slave (
    input  rx_data, rx_valid, tx_busy,
    output tx_data, tx_start, de, frame_len, frame_done, err_ovf, err_tmo, rx_drop
  );
endinterface

// File: rtl/rs485_frame_echo.sv
// Frames RX bytes between START_CHAR and a terminator, buffers one frame, echoes it with DE guard time.
// Optional saturating frame/error counters under `RS485_FRAME_STATS_EN.
module rs485_frame_echo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 6,
  parameter logic [DATA_W-1:0] START_CHAR = DATA_W'(8'h53),
  parameter logic [DATA_W-1:0] TERM_CHAR0 = DATA_W'(8'h0D),
  parameter logic [DATA_W-1:0] TERM_CHAR1 = DATA_W'(8'h0A),
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned GUARD_CYC   = 4
) (
  input  logic clk,
  input  logic reset,
  rs485_frame_echo_if.slave bus
`ifdef RS485_FRAME_STATS_EN
  ,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_ovf,
  output logic [15:0] stat_tmo
`endif
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GRD_W = $clog2(GUARD_CYC + 1);
  localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {R_IDLE, R_BODY, R_HOLD} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_GUARD_ON, T_FETCH, T_SEND, T_WAIT, T_GUARD_OFF} tx_state_t;

  rx_state_t         rx_state;
  tx_state_t         tx_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr, frame_len;
  logic [TMR_W-1:0]  timer;
  logic [GRD_W-1:0]  guard_cnt;
  logic [DATA_W-1:0] rd_data, tx_data;
  logic              frame_done, err_ovf, err_tmo, rx_drop, tx_start, de, wait_arm;
  logic              is_term;

  assign is_term = (bus.rx_data == TERM_CHAR0) || (bus.rx_data == TERM_CHAR1);

  // Receive framing and buffer ownership.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= R_IDLE;
      wptr       <= '0;
      timer      <= '0;
      frame_len  <= '0;
      frame_done <= 1'b0;
      err_ovf    <= 1'b0;
      err_tmo    <= 1'b0;
      rx_drop    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_ovf    <= 1'b0;
      err_tmo    <= 1'b0;
      rx_drop    <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (bus.rx_valid && bus.rx_data == START_CHAR) begin
            mem[0]   <= bus.rx_data;
            wptr     <= PTR_W'(1);
            timer    <= '0;
            rx_state <= R_BODY;
          end
        end
        R_BODY: begin
          if (bus.rx_valid) begin
            mem[wptr[ADDR_W-1:0]] <= bus.rx_data;
            wptr  <= wptr + PTR_W'(1);
            timer <= '0;
            if (is_term) begin
              frame_len  <= wptr + PTR_W'(1);
              frame_done <= 1'b1;
              rx_state   <= R_HOLD;
            end else if (wptr == LAST_ADDR) begin
              err_ovf  <= 1'b1;
              rx_state <= R_IDLE;
            end
          end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
            err_tmo  <= 1'b1;
            rx_state <= R_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        R_HOLD: begin
          if (bus.rx_valid) rx_drop <= 1'b1;
          // frame_done still high means TX has not yet left T_IDLE for this frame.
          if (tx_state == T_IDLE && !frame_done) rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Echo transmitter with driver-enable turnaround guard.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state  <= T_IDLE;
      rptr      <= '0;
      guard_cnt <= '0;
      rd_data   <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      de        <= 1'b0;
      wait_arm  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (tx_state)
        T_IDLE: begin
          if (frame_done) begin
            de        <= 1'b1;
            guard_cnt <= '0;
            tx_state  <= T_GUARD_ON;
          end
        end
        T_GUARD_ON: begin
          if (guard_cnt == GRD_W'(GUARD_CYC - 1)) begin
            rptr     <= '0;
            tx_state <= T_FETCH;
          end else begin
            guard_cnt <= guard_cnt + GRD_W'(1);
          end
        end
        T_FETCH: begin
          rd_data  <= mem[rptr[ADDR_W-1:0]];
          tx_state <= T_SEND;
        end
        T_SEND: begin
          if (!bus.tx_busy) begin
            tx_data  <= rd_data;
            tx_start <= 1'b1;
            wait_arm <= 1'b0;
            tx_state <= T_WAIT;
          end
        end
        T_WAIT: begin
          // The UART needs a clock to raise busy after the strobe.
          if (!wait_arm) begin
            wait_arm <= 1'b1;
          end else if (!bus.tx_busy) begin
            rptr <= rptr + PTR_W'(1);
            if ((rptr + PTR_W'(1)) < frame_len) begin
              tx_state <= T_FETCH;
            end else begin
              guard_cnt <= '0;
              tx_state  <= T_GUARD_OFF;
            end
          end
        end
        T_GUARD_OFF: begin
          if (guard_cnt == GRD_W'(GUARD_CYC - 1)) begin
            de       <= 1'b0;
            tx_state <= T_IDLE;
          end else begin
            guard_cnt <= guard_cnt + GRD_W'(1);
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  assign bus.tx_data    = tx_data;
  assign bus.tx_start   = tx_start;
  assign bus.de         = de;
  assign bus.frame_len  = frame_len;
  assign bus.frame_done = frame_done;
  assign bus.err_ovf    = err_ovf;
  assign bus.err_tmo    = err_tmo;
  assign bus.rx_drop    = rx_drop;

`ifdef RS485_FRAME_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_frames <= '0;
      stat_ovf    <= '0;
      stat_tmo    <= '0;
    end else begin
      if (frame_done && stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
      if (err_ovf && stat_ovf != 16'hFFFF)       stat_ovf    <= stat_ovf + 16'd1;
      if (err_tmo && stat_tmo != 16'hFFFF)       stat_tmo    <= stat_tmo + 16'd1;
    end
  end
`endif
endmodule
